// File: rtl/r4_pkg.sv
// Types and helpers shared by the radix-4 butterfly load and drain sequencers.
// R4_DIGIT_REV_EN selects digit-reversed (0,2,1,3) output order instead of natural order.
package r4_pkg;

  localparam int unsigned R4_N  = 4;
  localparam int unsigned R4_DW = 16;

  typedef struct packed {
    logic signed [R4_DW-1:0] re;
    logic signed [R4_DW-1:0] im;
  } cplx_t;

  // Maps a drain step to the butterfly output index presented at that step.
  function automatic logic [1:0] r4_ord(input logic [1:0] seq);
`ifdef R4_DIGIT_REV_EN
    return {seq[0], seq[1]};
`else
    return seq;
`endif
  endfunction

endpackage

// File: rtl/r4_quad_pingpong.sv
// Two-slot quad register file: one slot fills while the other drains.
module r4_quad_pingpong
  import r4_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_en_i,
  input  logic [R4_N-1:0][2*DW-1:0]   wr_quad_i,
  input  logic                        rd_release_i,
  output logic [1:0]                  occ_o,
  output logic [R4_N-1:0][2*DW-1:0]   head_quad_o,
  output logic [R4_N-1:0][2*DW-1:0]   next_quad_o
);

  logic [1:0][R4_N-1:0][2*DW-1:0] slot_q;
  logic                           wr_ptr_q;
  logic                           rd_ptr_q;
  logic [1:0]                     occ_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (wr_en_i) begin
        slot_q[wr_ptr_q] <= wr_quad_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (rd_release_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, wr_en_i} - {1'b0, rd_release_i};
    end
  end

  assign occ_o       = occ_q;
  assign head_quad_o = slot_q[rd_ptr_q];
  // Only meaningful when both slots are occupied.
  assign next_quad_o = slot_q[~rd_ptr_q];

endmodule

// File: rtl/r4_unit_drain.sv
// Radix-4 butterfly output sequencer: serialises quads into 4 samples on a valid/ready stream.
// Output order follows r4_ord(), which honours R4_DIGIT_REV_EN.
module r4_unit_drain
  import r4_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] in_y0,
  input  logic [2*DW-1:0] in_y1,
  input  logic [2*DW-1:0] in_y2,
  input  logic [2*DW-1:0] in_y3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_data,
  output logic [1:0]      out_idx,
  output logic            out_first,
  output logic            out_last
);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e                     state_q;
  logic [1:0]                 seq_q;
  logic [1:0]                 occ;
  logic [R4_N-1:0][2*DW-1:0]  in_quad;
  logic [R4_N-1:0][2*DW-1:0]  head_quad;
  logic [R4_N-1:0][2*DW-1:0]  next_quad;
  logic                       accept;
  logic                       fire;
  logic                       last_fire;
  logic [1:0]                 seq_nxt;
  logic [1:0]                 ord_nxt;
  logic [1:0]                 ord_zero;

  assign in_quad   = {in_y3, in_y2, in_y1, in_y0};
  // A slot freed by this cycle's last sample is only reusable after the edge.
  assign in_ready  = (occ != 2'd2);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign last_fire = fire && (seq_q == 2'd3);
  assign seq_nxt   = seq_q + 2'd1;
  assign ord_nxt   = r4_ord(seq_nxt);
  assign ord_zero  = r4_ord(2'd0);

  r4_quad_pingpong #(
    .DW (DW)
  ) u_pingpong (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_en_i      (accept),
    .wr_quad_i    (in_quad),
    .rd_release_i (last_fire),
    .occ_o        (occ),
    .head_quad_o  (head_quad),
    .next_quad_o  (next_quad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      seq_q     <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= 2'd0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q   <= StDrain;
            seq_q     <= 2'd0;
            out_valid <= 1'b1;
            out_data  <= in_quad[ord_zero];
            out_idx   <= ord_zero;
            out_first <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        StDrain: begin
          if (fire) begin
            if (seq_q != 2'd3) begin
              seq_q     <= seq_nxt;
              out_data  <= head_quad[ord_nxt];
              out_idx   <= ord_nxt;
              out_first <= 1'b0;
              out_last  <= (seq_nxt == 2'd3);
            end else begin
              seq_q <= 2'd0;
              if (occ == 2'd2) begin
                out_data  <= next_quad[ord_zero];
                out_idx   <= ord_zero;
                out_first <= 1'b1;
                out_last  <= 1'b0;
              end else if (accept) begin
                // Incoming quad lands in the slot that becomes head at this edge.
                out_data  <= in_quad[ord_zero];
                out_idx   <= ord_zero;
                out_first <= 1'b1;
                out_last  <= 1'b0;
              end else begin
                state_q   <= StIdle;
                out_valid <= 1'b0;
                out_idx   <= 2'd0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
